mem_ctrl_arbiter: RTL and testbench
===================================

Name: mem_ctrl_arbiter

Overview:
- Parametrised N-channel arbiter that replaces the fixed per-cache memory-controller ports at core top level.
- Multiplexes block read/write requests from N_CH clients (channel 0 = icache, channel 1 = dcache by default) onto one main-memory controller port.
- Tracks outstanding requests in an in-order tag FIFO and routes each response back to its originating channel.
- Supports round-robin or fixed-priority arbitration and optional write acknowledgements.

Parameters:
- N_CH, 2, number of client channels (≥2)
- ADDR_W, 26, main-memory block-address width
- BLOCK_W, 512, block data width
- MAX_OUT, 4, outstanding-response tag FIFO depth (power of 2)
- RR_MODE, 1, 1 = round-robin; 0 = fixed priority, lowest index wins
- WRITE_RESP, 0, 1 = writes also return a response (ack), routed like reads

Ports:
- clk  in  1  clock
- rst_aH  in  1  asynchronous active-high reset
- ch_req_valid  in  N_CH  per-channel request valid
- ch_req_type  in  N_CH  per-channel 0: read, 1: write
- ch_req_block_addr  in  N_CH*ADDR_W  per-channel block address
- ch_req_block_data  in  N_CH*BLOCK_W  per-channel write data
- ch_req_ready  out  N_CH  per-channel request accepted this cycle
- ch_resp_valid  out  N_CH  per-channel response valid (one-hot or zero)
- ch_resp_block_data  out  BLOCK_W  response data, shared by all channels
- mem_req_valid  out  1  request to memory controller
- mem_req_type  out  1  0: read, 1: write
- mem_req_block_addr  out  ADDR_W  block address
- mem_req_block_data  out  BLOCK_W  write data
- mem_req_ready  in  1  memory controller accepts request
- mem_resp_valid  in  1  memory response valid; responses arrive in request order
- mem_resp_block_data  in  BLOCK_W  response data
- outstanding_cnt  out  $clog2(MAX_OUT)+1  number of tags in flight
- err_unexpected_resp  out  1  sticky: response arrived with tag FIFO empty

Behaviour:
- Reset (async, rst_aH=1): all outputs 0, RR pointer 0, output register empty, tag FIFO empty, error flag cleared. Reset mid-operation discards in-flight tags; any later responses set err_unexpected_resp.
- Output stage: single request register drives mem_req_*. mem_req_valid=1 while full. Entry held stable until mem_req_valid && mem_req_ready.
- Capture condition: register empty, or draining this cycle.
- Tag need: a request needs a tag if it is a read, or if WRITE_RESP=1. A request needing a tag is eligible only when the tag FIFO is not full. Tags are counted at capture, not at mem handshake.
- Grant:
  - RR_MODE=1: first valid eligible channel scanning from RR pointer upward, mod N_CH.
  - RR_MODE=0: lowest valid eligible index.
  - Exactly one ch_req_ready bit is asserted, for the granted channel, only when the capture condition holds. Otherwise ch_req_ready=0.
  - Channel handshake occurs when ch_req_valid[i] && ch_req_ready[i].
- Latency: request appears on mem_req_* the cycle after the channel handshake. Zero bubbles with continuous mem_req_ready=1.
- RR pointer: after each grant, set to (granted+1) mod N_CH. No update without a grant.
- Tag FIFO: at capture of a tagged request, push the channel index. On mem_resp_valid, pop the head.
- Response path: registered. The cycle after mem_resp_valid, ch_resp_valid[head]=1 for one cycle and ch_resp_block_data = captured data. The data output holds its last value otherwise.
- Simultaneous push and pop in one cycle is allowed at full or empty. Full + pop + push leaves the count unchanged.
- Unexpected response: mem_resp_valid with FIFO empty (and no push this cycle) produces no ch_resp_valid, and err_unexpected_resp is set until reset.
- Untagged writes (WRITE_RESP=0): complete at the mem handshake; no response is generated.
- outstanding_cnt equals the FIFO occupancy, 0..MAX_OUT.
- A channel must hold its request stable until ready. Ready is never asserted for a non-valid channel.

Test Plan:
1. Reset, then ch0 read addr 0x10 and ch1 read addr 0x20, both valid, RR_MODE=1, mem_req_ready=1 → ch0 granted cycle 1 and ch1 granted cycle 2. mem_req_block_addr = 0x10 then 0x20 on consecutive cycles. outstanding_cnt reaches 2.
2. Memory returns 0xAA..A then 0xBB..B → ch_resp_valid = 01 with data 0xAA..A, then 10 with data 0xBB..B, one cycle after each mem_resp_valid. outstanding_cnt returns to 0.
3. MAX_OUT=4, ch1 issues 5 reads with no responses → 4 accepted. The 5th sees ch_req_ready=0 until a response pops a tag, then is accepted the same cycle as the pop.
4. WRITE_RESP=0, ch1 write addr 0x30 data 0x55..5 with mem_req_ready low for 3 cycles → mem_req_* stable for 3 cycles, ch_req_ready=0 for all channels meanwhile, outstanding_cnt stays 0.
5. RR_MODE=0, both channels continuously valid → ch0 granted every cycle, ch1 never. RR_MODE=1 → grants alternate 0,1,0,1.
6. Assert rst_aH with 2 tags in flight, release, then mem_resp_valid pulse → no ch_resp_valid and err_unexpected_resp=1 the next cycle.

Source files
------------

// File: rtl/mem_ctrl_arbiter.sv
// N-channel arbiter in front of a single main-memory controller port.
// Requests are funnelled through one output register; an in-order tag FIFO routes responses back.
module mem_ctrl_arbiter #(
  parameter int N_CH       = 2,
  parameter int ADDR_W     = 26,
  parameter int BLOCK_W    = 512,
  parameter int MAX_OUT    = 4,
  parameter int RR_MODE    = 1,
  parameter int WRITE_RESP = 0
) (
  input  logic                        clk,
  input  logic                        rst_aH,
  input  logic [N_CH-1:0]             ch_req_valid,
  input  logic [N_CH-1:0]             ch_req_type,
  input  logic [N_CH*ADDR_W-1:0]      ch_req_block_addr,
  input  logic [N_CH*BLOCK_W-1:0]     ch_req_block_data,
  output logic [N_CH-1:0]             ch_req_ready,
  output logic [N_CH-1:0]             ch_resp_valid,
  output logic [BLOCK_W-1:0]          ch_resp_block_data,
  output logic                        mem_req_valid,
  output logic                        mem_req_type,
  output logic [ADDR_W-1:0]           mem_req_block_addr,
  output logic [BLOCK_W-1:0]          mem_req_block_data,
  input  logic                        mem_req_ready,
  input  logic                        mem_resp_valid,
  input  logic [BLOCK_W-1:0]          mem_resp_block_data,
  output logic [$clog2(MAX_OUT):0]    outstanding_cnt,
  output logic                        err_unexpected_resp
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = CH_W + 1;

  logic [ADDR_W-1:0]  addr_arr [N_CH];
  logic [BLOCK_W-1:0] data_arr [N_CH];
  logic [N_CH-1:0]    needs_tag;
  logic [N_CH-1:0]    eligible;

  logic               req_full_reg;
  logic               req_type_reg;
  logic [ADDR_W-1:0]  req_addr_reg;
  logic [BLOCK_W-1:0] req_data_reg;
  logic [CH_W-1:0]    rr_ptr_reg;

  logic [CH_W-1:0]    tag_mem [MAX_OUT];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;

  logic [N_CH-1:0]    resp_valid_reg;
  logic [BLOCK_W-1:0] resp_data_reg;
  logic               err_reg;

  logic               tag_room;
  logic               capture_ok;
  logic               grant_found;
  logic [CH_W-1:0]    grant_idx;
  logic [SW-1:0]      scan_idx;
  logic               take;
  logic               push;
  logic               pop;
  logic [CH_W-1:0]    head;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a tagged request.
  assign tag_room = (count_reg != CNT_W'(MAX_OUT)) || mem_resp_valid;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign addr_arr[gi]     = ch_req_block_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi]     = ch_req_block_data[gi*BLOCK_W +: BLOCK_W];
      assign needs_tag[gi]    = ~ch_req_type[gi] | (WRITE_RESP != 0);
      assign eligible[gi]     = ch_req_valid[gi] & (~needs_tag[gi] | tag_room);
      assign ch_req_ready[gi] = take && (grant_idx == CH_W'(gi));
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (RR_MODE != 0) begin
        scan_idx = {1'b0, rr_ptr_reg} + SW'(k);
        if (scan_idx >= SW'(N_CH)) scan_idx = scan_idx - SW'(N_CH);
      end else begin
        scan_idx = SW'(k);
      end
      if (!grant_found && eligible[scan_idx[CH_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[CH_W-1:0];
      end
    end
  end

  assign capture_ok = !req_full_reg || mem_req_ready;
  assign take       = grant_found && capture_ok && !rst_aH;
  assign push       = take && needs_tag[grant_idx];
  // With an empty FIFO, a same-cycle push is popped straight through.
  assign pop        = mem_resp_valid && ((count_reg != '0) || push);
  assign head       = (count_reg == '0) ? grant_idx : tag_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_reg] <= grant_idx;
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      req_full_reg   <= 1'b0;
      req_type_reg   <= 1'b0;
      req_addr_reg   <= '0;
      req_data_reg   <= '0;
      rr_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      resp_valid_reg <= '0;
      resp_data_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (take) begin
        req_full_reg <= 1'b1;
        req_type_reg <= ch_req_type[grant_idx];
        req_addr_reg <= addr_arr[grant_idx];
        req_data_reg <= data_arr[grant_idx];
        rr_ptr_reg   <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
      end else if (mem_req_ready) begin
        req_full_reg <= 1'b0;
      end

      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      resp_valid_reg <= pop ? (N_CH'(1) << head) : '0;
      if (pop) resp_data_reg <= mem_resp_block_data;
      if (mem_resp_valid && !pop) err_reg <= 1'b1;
    end
  end

  assign mem_req_valid       = req_full_reg;
  assign mem_req_type        = req_type_reg;
  assign mem_req_block_addr  = req_addr_reg;
  assign mem_req_block_data  = req_data_reg;
  assign ch_resp_valid       = resp_valid_reg;
  assign ch_resp_block_data  = resp_data_reg;
  assign outstanding_cnt     = count_reg;
  assign err_unexpected_resp = err_reg;

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Scoreboard bench for mem_ctrl_arbiter: directed scenarios plus queued expectations for
// memory requests and routed responses.
module tb_mem_ctrl_arbiter;
  localparam int N = 2, AW = 26, BW = 512, MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req_valid, req_type, valid_b;
  logic [AW-1:0]   req_addr [N];
  logic [BW-1:0]   req_data [N];
  logic [N*AW-1:0] addr_flat;
  logic [N*BW-1:0] data_flat;
  logic [N-1:0]    ch_req_ready, ch_resp_valid, ready_b, resp_valid_b;
  logic [BW-1:0]   ch_resp_block_data, resp_data_b;
  logic            mem_req_valid, mem_req_type, mem_req_ready;
  logic [AW-1:0]   mem_req_block_addr;
  logic [BW-1:0]   mem_req_block_data;
  logic            mem_resp_valid;
  logic [BW-1:0]   mem_resp_data;
  logic [$clog2(MO):0] outstanding_cnt, cnt_b;
  logic            err_unexpected_resp, err_b;
  logic            mv_b, mt_b;
  logic [AW-1:0]   ma_b;
  logic [BW-1:0]   md_b;

  assign addr_flat = {req_addr[1], req_addr[0]};
  assign data_flat = {req_data[1], req_data[0]};

  always #5 clk = ~clk;

  mem_ctrl_arbiter #(.N_CH(N), .ADDR_W(AW), .BLOCK_W(BW), .MAX_OUT(MO), .RR_MODE(1), .WRITE_RESP(0)) dut (
    .clk(clk), .rst_aH(rst),
    .ch_req_valid(req_valid), .ch_req_type(req_type),
    .ch_req_block_addr(addr_flat), .ch_req_block_data(data_flat),
    .ch_req_ready(ch_req_ready), .ch_resp_valid(ch_resp_valid),
    .ch_resp_block_data(ch_resp_block_data),
    .mem_req_valid(mem_req_valid), .mem_req_type(mem_req_type),
    .mem_req_block_addr(mem_req_block_addr), .mem_req_block_data(mem_req_block_data),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_block_data(mem_resp_data),
    .outstanding_cnt(outstanding_cnt), .err_unexpected_resp(err_unexpected_resp)
  );

  // Fixed-priority instance, fed writes only, memory always ready.
  mem_ctrl_arbiter #(.N_CH(N), .ADDR_W(AW), .BLOCK_W(BW), .MAX_OUT(MO), .RR_MODE(0), .WRITE_RESP(0)) dut_fp (
    .clk(clk), .rst_aH(rst),
    .ch_req_valid(valid_b), .ch_req_type(req_type),
    .ch_req_block_addr(addr_flat), .ch_req_block_data(data_flat),
    .ch_req_ready(ready_b), .ch_resp_valid(resp_valid_b),
    .ch_resp_block_data(resp_data_b),
    .mem_req_valid(mv_b), .mem_req_type(mt_b),
    .mem_req_block_addr(ma_b), .mem_req_block_data(md_b),
    .mem_req_ready(1'b1), .mem_resp_valid(1'b0),
    .mem_resp_block_data(mem_resp_data),
    .outstanding_cnt(cnt_b), .err_unexpected_resp(err_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct { logic typ; logic [AW-1:0] addr; logic [BW-1:0] data; } req_t;
  typedef struct { int ch; logic [BW-1:0] data; } resp_t;
  req_t  exp_req[$];
  resp_t exp_resp[$];
  int    exp_tags[$];
  req_t  mon_r;
  resp_t mon_p;

  // Scoreboard: push on channel handshake / memory response, pop when the DUT emits.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) check("memreq_unexpected", BW'(mem_req_valid), BW'(0));
        else begin
          mon_r = exp_req.pop_front();
          check("memreq_type", BW'(mem_req_type), BW'(mon_r.typ));
          check("memreq_addr", BW'(mem_req_block_addr), BW'(mon_r.addr));
          check("memreq_data", mem_req_block_data, mon_r.data);
        end
      end
      if (ch_resp_valid != '0) begin
        if (exp_resp.size() == 0) check("resp_unexpected", BW'(ch_resp_valid), BW'(0));
        else begin
          mon_p = exp_resp.pop_front();
          check("resp_ch", BW'(ch_resp_valid), BW'(2'b01 << mon_p.ch));
          check("resp_data", ch_resp_block_data, mon_p.data);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && ch_req_ready[i]) begin
          mon_r.typ = req_type[i]; mon_r.addr = req_addr[i]; mon_r.data = req_data[i];
          exp_req.push_back(mon_r);
          if (!req_type[i]) exp_tags.push_back(i);
        end
      end
      if (mem_resp_valid && exp_tags.size() > 0) begin
        mon_p.ch = exp_tags.pop_front(); mon_p.data = mem_resp_data;
        exp_resp.push_back(mon_p);
      end
    end
  end

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic issue(input int ch, input logic typ, input logic [AW-1:0] a, input logic [BW-1:0] d);
    bit got = 1'b0;
    req_type[ch] = typ; req_addr[ch] = a; req_data[ch] = d; req_valid[ch] = 1'b1;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      got = ch_req_ready[ch];
    end
    check($sformatf("issue_ch%0d_%0h", ch, a), BW'(got), BW'(1));
    cyc();
    req_valid[ch] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_g;
    req_valid = '0; req_type = '0; valid_b = '0;
    req_addr[0] = '0; req_addr[1] = '0; req_data[0] = '0; req_data[1] = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

    // Reset state, including ready suppressed while in reset
    repeat (2) @(posedge clk);
    req_valid = 2'b11;
    @(negedge clk);
    check("rst_ready", BW'(ch_req_ready), BW'(0));
    check("rst_memvalid", BW'(mem_req_valid), BW'(0));
    check("rst_cnt", BW'(outstanding_cnt), BW'(0));
    check("rst_err", BW'(err_unexpected_resp), BW'(0));
    check("rst_resp", BW'(ch_resp_valid), BW'(0));
    cyc();
    req_valid = '0; rst = 1'b0;
    cyc();

    // 1: two reads, round-robin from channel 0
    req_type = 2'b00; req_addr[0] = 26'h10; req_addr[1] = 26'h20;
    req_data[0] = {16{32'hC0C0_0000}}; req_data[1] = {16{32'hC1C1_0001}};
    mem_req_ready = 1'b1; req_valid = 2'b11;
    @(negedge clk);
    check("t1_ready_ch0", BW'(ch_req_ready), BW'(2'b01));
    check("t1_idle", BW'(mem_req_valid), BW'(0));
    cyc(); req_valid = 2'b10;
    @(negedge clk);
    check("t1_ready_ch1", BW'(ch_req_ready), BW'(2'b10));
    check("t1_mv0", BW'(mem_req_valid), BW'(1));
    check("t1_addr0", BW'(mem_req_block_addr), BW'(26'h10));
    check("t1_cnt1", BW'(outstanding_cnt), BW'(1));
    cyc(); req_valid = 2'b00;
    @(negedge clk);
    check("t1_addr1", BW'(mem_req_block_addr), BW'(26'h20));
    check("t1_cnt2", BW'(outstanding_cnt), BW'(2));
    check("t1_ready_none", BW'(ch_req_ready), BW'(0));
    cyc();

    // 2: responses routed in order
    mem_resp_valid = 1'b1; mem_resp_data = {16{32'hAAAA_AAAA}};
    @(negedge clk);
    check("t2_mv_idle", BW'(mem_req_valid), BW'(0));
    cyc(); mem_resp_data = {16{32'hBBBB_BBBB}};
    @(negedge clk);
    check("t2_resp0", BW'(ch_resp_valid), BW'(2'b01));
    check("t2_data0", ch_resp_block_data, {16{32'hAAAA_AAAA}});
    check("t2_cnt1", BW'(outstanding_cnt), BW'(1));
    cyc(); mem_resp_valid = 1'b0; mem_resp_data = '0;
    @(negedge clk);
    check("t2_resp1", BW'(ch_resp_valid), BW'(2'b10));
    check("t2_data1", ch_resp_block_data, {16{32'hBBBB_BBBB}});
    check("t2_cnt0", BW'(outstanding_cnt), BW'(0));
    cyc();
    @(negedge clk);
    check("t2_resp_idle", BW'(ch_resp_valid), BW'(0));
    check("t2_data_hold", ch_resp_block_data, {16{32'hBBBB_BBBB}});
    cyc();

    // 3: fill the tag FIFO, fifth read waits for a pop
    for (int k = 0; k < 4; k++) issue(1, 1'b0, 26'h100 + AW'(k), {16{32'h3000_0000 + k}});
    req_type[1] = 1'b0; req_addr[1] = 26'h104; req_data[1] = {16{32'h3000_0004}}; req_valid[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_full_ready", BW'(ch_req_ready), BW'(0));
      check("t3_cnt_full", BW'(outstanding_cnt), BW'(4));
      cyc();
    end
    mem_resp_valid = 1'b1; mem_resp_data = {16{32'h3333_0000}};
    @(negedge clk);
    check("t3_pop_ready", BW'(ch_req_ready), BW'(2'b10));
    cyc(); req_valid[1] = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    check("t3_cnt_kept", BW'(outstanding_cnt), BW'(4));
    for (int k = 1; k <= 4; k++) begin
      mem_resp_valid = 1'b1; mem_resp_data = {16{32'h3333_0000 + k}};
      cyc();
    end
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("t3_cnt_drained", BW'(outstanding_cnt), BW'(0));
    cyc();

    // 4: untagged write stalled by memory; other channel blocked meanwhile
    mem_req_ready = 1'b0;
    issue(1, 1'b1, 26'h30, {128{4'h5}});
    req_type[0] = 1'b0; req_addr[0] = 26'h40; req_data[0] = {16{32'h4040_4040}}; req_valid[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t4_mv", BW'(mem_req_valid), BW'(1));
      check("t4_type", BW'(mem_req_type), BW'(1));
      check("t4_addr", BW'(mem_req_block_addr), BW'(26'h30));
      check("t4_data", mem_req_block_data, {128{4'h5}});
      check("t4_ready", BW'(ch_req_ready), BW'(0));
      check("t4_cnt", BW'(outstanding_cnt), BW'(0));
      cyc();
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    check("t4_ready_on_drain", BW'(ch_req_ready), BW'(2'b01));
    cyc(); req_valid[0] = 1'b0;
    @(negedge clk);
    check("t4_cnt1", BW'(outstanding_cnt), BW'(1));
    check("t4_addr_rd", BW'(mem_req_block_addr), BW'(26'h40));
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = {16{32'h4444_0000}};
    cyc(); mem_resp_valid = 1'b0;
    cyc();

    // 5: both channels continuously valid (writes); RR alternates, fixed priority sticks to ch0
    req_type = 2'b11; req_addr[0] = 26'h50; req_addr[1] = 26'h60;
    req_data[0] = {16{32'h5050_5050}}; req_data[1] = {16{32'h6060_6060}};
    req_valid = 2'b11; valid_b = 2'b11;
    exp_g = 1;  // last grant in scenario 4 went to channel 0
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t5_rr_%0d", k), BW'(ch_req_ready), BW'(2'b01 << exp_g));
      check($sformatf("t5_fp_%0d", k), BW'(ready_b), BW'(2'b01));
      exp_g = 1 - exp_g;
      cyc();
    end
    req_valid = '0; valid_b = 2'b10;
    @(negedge clk);
    check("t5_fp_ch1_alone", BW'(ready_b), BW'(2'b10));
    cyc(); valid_b = '0;
    cyc(); cyc();
    @(negedge clk);
    check("sb_req_left", BW'(exp_req.size()), BW'(0));
    check("sb_resp_left", BW'(exp_resp.size()), BW'(0));
    cyc();

    // 6: reset with tags in flight, then a stray response
    issue(0, 1'b0, 26'h70, {16{32'h7070_7070}});
    issue(1, 1'b0, 26'h80, {16{32'h8080_8080}});
    cyc();
    @(negedge clk);
    check("t6_cnt2", BW'(outstanding_cnt), BW'(2));
    cyc();
    rst = 1'b1;
    exp_req.delete(); exp_tags.delete(); exp_resp.delete();
    @(negedge clk);
    check("t6_rst_cnt", BW'(outstanding_cnt), BW'(0));
    check("t6_rst_err", BW'(err_unexpected_resp), BW'(0));
    cyc();
    rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = {16{32'hDEAD_BEEF}};
    cyc(); mem_resp_valid = 1'b0;
    @(negedge clk);
    check("t6_err", BW'(err_unexpected_resp), BW'(1));
    check("t6_noresp", BW'(ch_resp_valid), BW'(0));
    cyc(); cyc();
    @(negedge clk);
    check("t6_err_sticky", BW'(err_unexpected_resp), BW'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
